mem_arbiter: RTL and testbench

- Shared-memory controller for the pipelined CPU once the instruction and data memories move behind I-cache and D-cache.
- Arbitrates one multi-cycle, pipelined main memory among three requesters: I-cache block fills, D-cache block fills and D-cache write-through stores.
- Sequences each block fill as BLOCK_WORDS back-to-back word reads and steers the returning words into the requesting cache's data array.
- The CPU stalls on cache misses while this block is busy; the block itself has no knowledge of the pipeline.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: grants one of store / D-fill / I-fill per idle cycle
// and sequences each fill as a burst of pipelined word reads into the chosen cache.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4,
  parameter int WORD_BITS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_miss,
  input  logic [15:0]          i_miss_addr,
  output logic                 i_fill_we,
  output logic [WORD_BITS-1:0] i_fill_word,
  output logic [15:0]          i_fill_data,
  output logic                 i_fill_done,
  input  logic                 d_miss,
  input  logic [15:0]          d_miss_addr,
  output logic                 d_fill_we,
  output logic [WORD_BITS-1:0] d_fill_word,
  output logic [15:0]          d_fill_data,
  output logic                 d_fill_done,
  input  logic                 d_wr_req,
  input  logic [15:0]          d_wr_addr,
  input  logic [15:0]          d_wr_data,
  output logic                 d_wr_ack,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_data_out,
  input  logic [15:0]          mem_data_in,
  input  logic                 mem_data_valid,
  output logic                 busy
);

  localparam int BaseBits = 15 - WORD_BITS;
  localparam logic [WORD_BITS-1:0] LastWord = WORD_BITS'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, D_FILL, I_FILL} state_t;

  state_t               state_q;
  logic [WORD_BITS-1:0] icnt_q;
  logic [WORD_BITS-1:0] rcnt_q;
  logic [BaseBits-1:0]  base_q;
  logic                 memEn_q;
  logic                 memWr_q;
  logic [15:0]          memAddr_q;
  logic [15:0]          memData_q;
  logic                 wrAck_q;

  logic inFill;
  logic fillBeat;
  logic lastBeat;
  logic unusedBits;

  // Fill timing follows mem_data_valid, so the latency value and the in-block
  // address bits of the miss addresses never reach any logic.
  assign unusedBits = ^{i_miss_addr[WORD_BITS:0], d_miss_addr[WORD_BITS:0], MEM_LATENCY > 0};

  assign inFill   = (state_q == D_FILL) || (state_q == I_FILL);
  assign fillBeat = inFill && mem_data_valid;
  assign lastBeat = fillBeat && (rcnt_q == LastWord);

  // Memory-side outputs are registered: each edge prepares the next cycle's access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      icnt_q    <= '0;
      rcnt_q    <= '0;
      base_q    <= '0;
      memEn_q   <= 1'b0;
      memWr_q   <= 1'b0;
      memAddr_q <= '0;
      memData_q <= '0;
      wrAck_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_wr_req) begin
            state_q   <= WRITE;
            memEn_q   <= 1'b1;
            memWr_q   <= 1'b1;
            memAddr_q <= d_wr_addr;
            memData_q <= d_wr_data;
            wrAck_q   <= 1'b1;
          end else if (d_miss) begin
            state_q   <= D_FILL;
            base_q    <= d_miss_addr[15:WORD_BITS+1];
            memEn_q   <= 1'b1;
            memAddr_q <= {d_miss_addr[15:WORD_BITS+1], (WORD_BITS+1)'(0)};
          end else if (i_miss) begin
            state_q   <= I_FILL;
            base_q    <= i_miss_addr[15:WORD_BITS+1];
            memEn_q   <= 1'b1;
            memAddr_q <= {i_miss_addr[15:WORD_BITS+1], (WORD_BITS+1)'(0)};
          end
        end
        WRITE: begin
          state_q   <= IDLE;
          memEn_q   <= 1'b0;
          memWr_q   <= 1'b0;
          memAddr_q <= '0;
          memData_q <= '0;
          wrAck_q   <= 1'b0;
        end
        D_FILL, I_FILL: begin
          if (memEn_q) begin
            if (icnt_q == LastWord) begin
              memEn_q   <= 1'b0;
              memAddr_q <= '0;
            end else begin
              icnt_q    <= icnt_q + 1'b1;
              memAddr_q <= {base_q, icnt_q + 1'b1, 1'b0};
            end
          end
          if (fillBeat) begin
            rcnt_q <= rcnt_q + 1'b1;
          end
          // The final returned word ends the fill and overrides the updates above.
          if (lastBeat) begin
            state_q   <= IDLE;
            icnt_q    <= '0;
            rcnt_q    <= '0;
            memEn_q   <= 1'b0;
            memAddr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en       = memEn_q;
  assign mem_wr       = memWr_q;
  assign mem_addr     = memAddr_q;
  assign mem_data_out = memData_q;
  assign d_wr_ack     = wrAck_q;
  assign busy         = (state_q != IDLE);

  // Returning words steer straight through to the cache that owns the fill.
  assign i_fill_we   = fillBeat && (state_q == I_FILL);
  assign i_fill_word = i_fill_we ? rcnt_q : '0;
  assign i_fill_data = i_fill_we ? mem_data_in : '0;
  assign i_fill_done = i_fill_we && (rcnt_q == LastWord);

  assign d_fill_we   = fillBeat && (state_q == D_FILL);
  assign d_fill_word = d_fill_we ? rcnt_q : '0;
  assign d_fill_data = d_fill_we ? mem_data_in : '0;
  assign d_fill_done = d_fill_we && (rcnt_q == LastWord);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random requests, every output
// compared each cycle against a transaction-level timing model of the arbiter.
module tb_mem_arbiter;

  localparam int BW  = 8;
  localparam int LAT = 4;
  localparam int WB  = 3;
  localparam int FILL_CYCLES = BW + LAT;
  localparam logic [15:0] BLOCK_MASK = 16'(2 * BW - 1);

  localparam int M_IDLE  = 0;
  localparam int M_WRITE = 1;
  localparam int M_DFILL = 2;
  localparam int M_IFILL = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic i_fill_we, i_fill_done, d_fill_we, d_fill_done;
  logic [WB-1:0] i_fill_word, d_fill_word;
  logic [15:0] i_fill_data, d_fill_data;
  logic d_wr_ack, mem_en, mem_wr, busy;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic mem_data_valid;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(BW), .MEM_LATENCY(LAT), .WORD_BITS(WB)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_fill_we(i_fill_we), .i_fill_word(i_fill_word), .i_fill_data(i_fill_data), .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_fill_we(d_fill_we), .d_fill_word(d_fill_word), .d_fill_data(d_fill_data), .d_fill_done(d_fill_done),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory: reads return mem[a] = a exactly LAT cycles after issue.
  logic [15:0] memDue [int];
  logic injectValid = 1'b0;
  logic [15:0] injectData = 16'h0;

  // Model: current transaction kind, the cycle it began and its operands.
  int mKind = M_IDLE;
  int mStart = 0;
  logic [15:0] mBase = 16'h0;
  logic [15:0] mWrAddr = 16'h0;
  logic [15:0] mWrData = 16'h0;
  logic lastAck = 1'b0;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%04h, expected 0x%04h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelCheck();
    int off;
    int word;
    logic eEn, eWr, eAck, beat, done;
    logic [15:0] eAddr, eData, fData, fWord;
    off = cyc - mStart;
    eEn = 0; eWr = 0; eAck = 0; beat = 0; done = 0;
    eAddr = 16'h0; eData = 16'h0; fData = 16'h0; fWord = 16'h0;
    if (mKind == M_WRITE) begin
      eEn = 1; eWr = 1; eAck = 1; eAddr = mWrAddr; eData = mWrData;
    end else if (mKind == M_DFILL || mKind == M_IFILL) begin
      if (off < BW) begin
        eEn = 1;
        eAddr = mBase + 16'(2 * off);
      end
      if (off >= LAT && off < LAT + BW) begin
        beat = 1;
        word = off - LAT;
        fWord = 16'(word);
        fData = mBase + 16'(2 * word);
        done = (word == BW - 1);
      end
    end
    lastAck = eAck;
    checkOutput("busy", 16'(busy), 16'(mKind != M_IDLE));
    checkOutput("mem_en", 16'(mem_en), 16'(eEn));
    checkOutput("mem_wr", 16'(mem_wr), 16'(eWr));
    checkOutput("mem_addr", mem_addr, eAddr);
    checkOutput("mem_data_out", mem_data_out, eData);
    checkOutput("d_wr_ack", 16'(d_wr_ack), 16'(eAck));
    checkOutput("i_fill_we", 16'(i_fill_we), 16'(beat && mKind == M_IFILL));
    checkOutput("i_fill_word", 16'(i_fill_word), (mKind == M_IFILL) ? fWord : 16'h0);
    checkOutput("i_fill_data", i_fill_data, (mKind == M_IFILL) ? fData : 16'h0);
    checkOutput("i_fill_done", 16'(i_fill_done), 16'(done && mKind == M_IFILL));
    checkOutput("d_fill_we", 16'(d_fill_we), 16'(beat && mKind == M_DFILL));
    checkOutput("d_fill_word", 16'(d_fill_word), (mKind == M_DFILL) ? fWord : 16'h0);
    checkOutput("d_fill_data", d_fill_data, (mKind == M_DFILL) ? fData : 16'h0);
    checkOutput("d_fill_done", 16'(d_fill_done), 16'(done && mKind == M_DFILL));
  endtask

  task automatic modelAdvance();
    int dur;
    dur = (mKind == M_WRITE) ? 1 : FILL_CYCLES;
    if (rst) begin
      mKind = M_IDLE;
    end else if (mKind == M_IDLE) begin
      mStart = cyc + 1;
      if (d_wr_req) begin
        mKind = M_WRITE; mWrAddr = d_wr_addr; mWrData = d_wr_data;
      end else if (d_miss) begin
        mKind = M_DFILL; mBase = d_miss_addr & ~BLOCK_MASK;
      end else if (i_miss) begin
        mKind = M_IFILL; mBase = i_miss_addr & ~BLOCK_MASK;
      end
    end else if (cyc + 1 - mStart >= dur) begin
      mKind = M_IDLE;
    end
  endtask

  // One clock cycle: memory response, compare against the model, advance.
  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      if (mem_en === 1'b1 && mem_wr === 1'b0) memDue[cyc + LAT] = mem_addr;
      if (memDue.exists(cyc)) begin
        mem_data_valid = 1'b1;
        mem_data_in = memDue[cyc];
        memDue.delete(cyc);
      end else if (injectValid) begin
        mem_data_valid = 1'b1;
        mem_data_in = injectData;
      end else begin
        mem_data_valid = 1'b0;
        mem_data_in = 16'($urandom);
      end
      #1;
      modelCheck();
      modelAdvance();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_miss = 1'b1; i_miss_addr = 16'h0126;
    d_miss = 1'b0; d_miss_addr = 16'h0;
    d_wr_req = 1'b0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    mem_data_valid = 1'b0; mem_data_in = 16'h0;
    @(posedge clk);
    #1;

    $display("[TB] reset with i_miss held");
    applyStimulus(2);
    rst = 1'b0;

    $display("[TB] I-fill from 0x0126");
    applyStimulus(1);
    i_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);

    $display("[TB] simultaneous D and I misses");
    d_miss = 1'b1; d_miss_addr = 16'h2000;
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    applyStimulus(1);
    d_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);
    i_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);

    $display("[TB] store beats pending I miss");
    d_wr_req = 1'b1; d_wr_addr = 16'h3004; d_wr_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'h0010;
    applyStimulus(2);
    d_wr_req = 1'b0;
    applyStimulus(1);
    i_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);

    $display("[TB] reset in the middle of an I fill");
    i_miss = 1'b1; i_miss_addr = 16'h0100;
    applyStimulus(1);
    i_miss = 1'b0;
    applyStimulus(LAT + 3);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(BW + LAT);
    d_miss = 1'b1; d_miss_addr = 16'h4A5A;
    applyStimulus(1);
    d_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);

    $display("[TB] stray valid while idle");
    injectValid = 1'b1; injectData = 16'h5555;
    applyStimulus(2);
    injectValid = 1'b0;
    d_miss = 1'b1; d_miss_addr = 16'h7FFE;
    applyStimulus(1);
    d_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if (!d_wr_req && $urandom_range(0, 99) < 4) begin
        d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 8) d_miss = ~d_miss;
      if ($urandom_range(0, 99) < 15) d_miss_addr = 16'($urandom);
      if ($urandom_range(0, 99) < 8) i_miss = ~i_miss;
      if ($urandom_range(0, 99) < 15) i_miss_addr = 16'($urandom);
      applyStimulus(1);
      if (lastAck) d_wr_req = 1'b0;
    end
    i_miss = 1'b0; d_miss = 1'b0;
    applyStimulus(FILL_CYCLES + 8);
    if (d_wr_req) begin
      applyStimulus(3);
      d_wr_req = 1'b0;
      applyStimulus(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
